// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a circular prefetch FIFO.
//
// Presents the fetch PC to a combinational instruction ROM. Each returned word
// is captured together with its PC into a DEPTH-entry FIFO. Instructions are
// handed to the consumer over a valid/ready handshake. A redirect flushes the
// queue and restarts fetching at a new word-aligned PC.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an empty queue forward
// rom_data straight to the output in the same cycle it is fetched.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   rom_addr     out  current fetch PC
//   rom_data     in   instruction word at rom_addr, same cycle
//   out_valid    out  out_instr/out_pc carry a valid instruction
//   out_ready    in   consumer accepts the instruction this cycle
//   out_instr    out  head instruction, 0 when not valid
//   out_pc       out  PC of out_instr, 0 when not valid
//   redirect     in   flush queue and restart fetch at redirect_pc
//   redirect_pc  in   new fetch PC, bits [1:0] ignored
//   count        out  occupied entries, 0..DEPTH
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                rom_addr,
  input  logic [31:0]                rom_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] mem_pc_q    [DEPTH];
  logic [31:0] mem_instr_q [DEPTH];

  logic empty;
  logic byp;       // output is being fed straight from the ROM
  logic byp_take;  // forwarded word consumed directly, never stored
  logic pop;
  logic push;
  logic wr;
  logic rd;

  always_comb begin
    empty = (count_q == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = empty & ~redirect;
`else
    byp = 1'b0;
`endif
    out_valid = ~redirect & (~empty | byp);
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      if (byp) begin
        out_instr = rom_data;
        out_pc    = fetch_pc_q;
      end else begin
        out_instr = mem_instr_q[head_q];
        out_pc    = mem_pc_q[head_q];
      end
    end

    pop      = out_valid & out_ready;
    byp_take = byp & out_ready;
    push     = ~redirect & ((count_q < CW'(DEPTH)) | pop);
    // A bypassed transfer advances fetch but touches neither pointer.
    wr       = push & ~byp_take;
    rd       = pop & ~byp_take;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (wr) begin
        tail_d = tail_q + AW'(1);
      end
      if (rd) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      mem_pc_q[tail_q]    <= fetch_pc_q;
      mem_instr_q[tail_q] <= rom_data;
    end
  end

  assign rom_addr = fetch_pc_q;
  assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count)
  );

  always #5 clk = ~clk;

  // ROM contents: tag bits OR address.
  assign rom_data = 32'hA000_0000 | rom_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, instr} plus the next fetch address.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_ok = 0;

  initial forever begin
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    bit          direct;
    @(negedge clk);
    if (m_ok) begin
      direct  = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
      direct  = (mq.size() == 0) && !redirect;
`endif
      e_valid = !redirect && (mq.size() != 0 || direct);
      e_pc    = 32'h0;
      e_instr = 32'h0;
      if (e_valid) begin
        if (direct) begin
          e_pc    = m_pc;
          e_instr = 32'hA000_0000 | m_pc;
        end else begin
          e_pc    = mq[0][63:32];
          e_instr = mq[0][31:0];
        end
      end
      chk("m_valid", {31'h0, out_valid}, {31'h0, e_valid});
      chk("m_pc", out_pc, e_pc);
      chk("m_instr", out_instr, e_instr);
      chk("m_rom_addr", rom_addr, m_pc);
      chk("m_count", {29'h0, count}, mq.size());
    end
    // Advance model to the state after the coming rising edge.
    if (rst) begin
      mq.delete();
      m_pc = 32'h0;
      m_ok = 1;
    end else if (m_ok) begin
      if (redirect) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (e_valid && out_ready && mq.size() == 0) begin
        m_pc = m_pc + 32'd4;
      end else begin
        if (e_valid && out_ready) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          mq.push_back({m_pc, 32'hA000_0000 | m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt[6] = '{1, 2, 3, 4, 4, 4};
    logic [31:0] wrap_pcs[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int got;

    rst = 1'b1;
    out_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_count", {29'h0, count}, 32'h0);

    // Fill with the consumer stalled.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fill_count", {29'h0, count}, exp_cnt[i]);
    end
    chk("fill_rom_addr", rom_addr, 32'h10);
    chk("fill_pc", out_pc, 32'h0);
    chk("fill_instr", out_instr, 32'hA000_0000);

    // Drain at full rate; queue stays full.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", {31'h0, out_valid}, 32'h1);
      chk("drain_pc", out_pc, 32'(i * 4));
      chk("drain_count", {29'h0, count}, 32'd4);
      tick();
    end

    // Empty, then refill to three entries.
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_redir_count", {29'h0, count}, 32'd3);

    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_valid", {31'h0, out_valid}, 32'h0);
    tick();
    redirect = 1'b0;
    out_ready = 1'b1;
    chk("redir_count", {29'h0, count}, 32'h0);
    chk("redir_rom_addr", rom_addr, 32'h100);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("redir_gap", {31'h0, out_valid}, 32'h0);
    tick();
`endif
    chk("redir_first_valid", {31'h0, out_valid}, 32'h1);
    chk("redir_first_pc", out_pc, 32'h100);
    chk("redir_first_instr", out_instr, 32'hA000_0100);

    // Reset beats redirect.
    rst = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    chk("rstredir_rom_addr", rom_addr, 32'h0);
    chk("rstredir_count", {29'h0, count}, 32'h0);

    // Fetch PC wraps modulo 2^32.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got < 4; i++) begin
      if (out_valid) begin
        chk("wrap_pc", out_pc, wrap_pcs[got]);
        got++;
      end
      tick();
    end
    chk("wrap_seen", 32'(got), 32'd4);

`ifdef FETCH_QUEUE_BYPASS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("byp_valid", {31'h0, out_valid}, 32'h1);
    chk("byp_pc", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("byp_count", {29'h0, count}, 32'h0);
      chk("byp_pc_seq", out_pc, 32'(i * 4));
      tick();
    end
`endif

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
